// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the regfile writeback arbiter and its scoreboard.
//   XLEN_DEF : default writeback data width
//   REG_ZERO : architectural x0, never written and never pending
//   wb_src_e : writeback source encoding, also the round-robin pointer value
//   wb_req_t : one writeback request (valid, destination, data)
package rf_wb_arbiter_pkg;

  localparam int         XLEN_DEF = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    SRC_LSU = 1'b0,
    SRC_ALU = 1'b1
  } wb_src_e;

  // The data field is sized by XLEN_DEF; the top casts into and out of it.
  typedef struct packed {
    logic                valid;
    logic [4:0]          rd;
    logic [XLEN_DEF-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for outstanding loads.
//   clk, rst      : clock, synchronous active-high reset
//   issue_load/rd : load dispatch request and its destination
//   issue_ready   : dispatch allowed (slot free, destination not already pending)
//   lsu_clr/rd    : load writeback granted this cycle, clears its pending bit
//   rs1_id/rs2_id : decode sources
//   stall_o       : decode must hold (a source has a pending load)
//   pending       : one bit per architectural register, bit 0 always 0
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_load,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic        lsu_clr,
  input  logic [4:0]  lsu_rd,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  output logic        stall_o,
  output logic [31:0] pending
);

  logic [3:0]  count;
  logic [31:0] pend_nxt;
  logic        issue_acc;

  // A second load to an already-pending register is held off so each
  // pending bit maps to exactly one in-flight load.
  assign issue_ready = (count < 4'(MAX_OUTSTANDING)) &&
                       ((issue_rd == REG_ZERO) || !pending[issue_rd]);
  assign issue_acc   = issue_load && issue_ready;

  assign stall_o = ((rs1_id != REG_ZERO) && pending[rs1_id]) ||
                   ((rs2_id != REG_ZERO) && pending[rs2_id]);

  // Clear before set so a same-index set wins.
  always_comb begin
    pend_nxt = pending;
    if (lsu_clr)
      pend_nxt[lsu_rd] = 1'b0;
    if (issue_acc && (issue_rd != REG_ZERO))
      pend_nxt[issue_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      count   <= '0;
    end else begin
      pending <= pend_nxt;
      unique case ({issue_acc, lsu_clr})
        2'b10:   count <= count + 4'd1;
        // A return with nothing outstanding is a protocol error; hold at 0.
        2'b01:   if (count != 4'd0) count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the regfile write port between the ALU and LSU writeback paths.
//   clk, rst                        : clock, synchronous active-high reset
//   alu_valid/rd/data, alu_ready    : ALU writeback request / accept
//   lsu_valid/rd/data, lsu_ready    : load return request / accept
//   issue_load/rd, issue_ready      : load dispatch into the scoreboard
//   rs1_id, rs2_id, stall_o         : decode RAW hazard check
//   rf_w_en, rf_rd_id, rf_wdata     : registered regfile write port
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int XLEN            = XLEN_DEF,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            issue_load,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  input  logic [4:0]      rs1_id,
  input  logic [4:0]      rs2_id,
  output logic            stall_o,
  output logic            rf_w_en,
  output logic [4:0]      rf_rd_id,
  output logic [XLEN-1:0] rf_wdata
);

  logic [31:0] pending;
  wb_src_e     rr_ptr;     // source favoured on the next contested cycle
  wb_req_t     alu_req, lsu_req, gnt_req;
  logic        alu_elig, lsu_elig, contest;

  assign alu_req = '{valid: alu_valid, rd: alu_rd, data: XLEN_DEF'(alu_data)};
  assign lsu_req = '{valid: lsu_valid, rd: lsu_rd, data: XLEN_DEF'(lsu_data)};

  // An ALU write to a register with an older load in flight must wait,
  // otherwise the load would land later and clobber the newer value.
  assign alu_elig = alu_req.valid && !pending[alu_req.rd];
  assign lsu_elig = lsu_req.valid;
  assign contest  = alu_elig && lsu_elig;

  assign lsu_ready = lsu_elig && (!alu_elig || (rr_ptr == SRC_LSU));
  assign alu_ready = alu_elig && !lsu_ready;

  always_comb begin
    gnt_req       = lsu_ready ? lsu_req : alu_req;
    gnt_req.valid = alu_ready || lsu_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= SRC_LSU;
      rf_w_en  <= 1'b0;
      rf_rd_id <= '0;
      rf_wdata <= '0;
    end else begin
      if (contest)
        rr_ptr <= lsu_ready ? SRC_ALU : SRC_LSU;
      // x0 writes are consumed but never reach the regfile.
      rf_w_en <= gnt_req.valid && (gnt_req.rd != REG_ZERO);
      if (gnt_req.valid) begin
        rf_rd_id <= gnt_req.rd;
        rf_wdata <= XLEN'(gnt_req.data);
      end
    end
  end

  rf_scoreboard #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .issue_load  (issue_load),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .lsu_clr     (lsu_ready),
    .lsu_rd      (lsu_rd),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .stall_o     (stall_o),
    .pending     (pending)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int XLEN = 32;
  localparam int MAXO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid, lsu_valid, issue_load;
  logic [4:0]      alu_rd, lsu_rd, issue_rd, rs1_id, rs2_id;
  logic [XLEN-1:0] alu_data, lsu_data;
  logic            alu_ready, lsu_ready, issue_ready, stall_o, rf_w_en;
  logic [4:0]      rf_rd_id;
  logic [XLEN-1:0] rf_wdata;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.XLEN(XLEN), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .issue_load(issue_load), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .stall_o(stall_o),
    .rf_w_en(rf_w_en), .rf_rd_id(rf_rd_id), .rf_wdata(rf_wdata)
  );

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Reference model: set of pending registers, number of loads in flight,
  // which source wins the next tie, and the write expected on the port.
  bit          m_pend [32];
  int          m_cnt;
  bit          m_fav_lsu;
  bit          m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_cnt = 0; m_fav_lsu = 1'b1; m_wen = 1'b0; m_rd = '0; m_data = '0;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_load = 0; issue_rd = 0; rs1_id = 0; rs2_id = 0;
  endtask

  // Check the DUT against the model for the current inputs, advance the
  // model, then step one clock. Returns 1ns after the rising edge.
  task automatic cyc();
    bit ae, le, ga, gl, ir, st, acc;
    #1;
    ae = alu_valid && !m_pend[alu_rd];
    le = lsu_valid;
    gl = le && (!ae || m_fav_lsu);
    ga = ae && !gl;
    ir = (m_cnt < MAXO) && (issue_rd == 0 || !m_pend[issue_rd]);
    st = (rs1_id != 0 && m_pend[rs1_id]) || (rs2_id != 0 && m_pend[rs2_id]);
    chk("m_alu_ready", alu_ready, ga);
    chk("m_lsu_ready", lsu_ready, gl);
    chk("m_issue_ready", issue_ready, ir);
    chk("m_stall", stall_o, st);
    chk("m_wen", rf_w_en, m_wen);
    if (m_wen) begin
      chk("m_rd", rf_rd_id, m_rd);
      chk("m_wdata", rf_wdata, m_data);
    end
    if (rst) model_reset();
    else begin
      if (ae && le) m_fav_lsu = !gl;
      m_wen = 1'b0;
      if (gl) begin m_wen = (lsu_rd != 0); m_rd = lsu_rd; m_data = lsu_data; end
      else if (ga) begin m_wen = (alu_rd != 0); m_rd = alu_rd; m_data = alu_data; end
      acc = issue_load && ir;
      if (gl) m_pend[lsu_rd] = 1'b0;
      if (acc && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      m_cnt = m_cnt + int'(acc) - int'(gl);
      if (m_cnt < 0) m_cnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1; cyc(); rst = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 0;

    // Reset state
    #1;
    chk("rst_wen", rf_w_en, 0);
    chk("rst_rd", rf_rd_id, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_stall", stall_o, 0);

    // ALU only
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
    #1 chk("alu_only_ready", alu_ready, 1);
    cyc();
    idle();
    #1;
    chk("alu_only_wen", rf_w_en, 1);
    chk("alu_only_rd", rf_rd_id, 5);
    chk("alu_only_wdata", rf_wdata, 32'h1234);
    cyc();
    #1 chk("alu_only_wen_drop", rf_w_en, 0);

    // Contention: LSU, ALU, LSU, ALU
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 3; alu_data = 32'h100 + i;
      lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h200 + i;
      #1;
      chk("cont_lsu_ready", lsu_ready, (i % 2 == 0));
      chk("cont_alu_ready", alu_ready, (i % 2 == 1));
      cyc();
      #1;
      chk("cont_rd", rf_rd_id, (i % 2 == 0) ? 4 : 3);
      chk("cont_wdata", rf_wdata, (i % 2 == 0) ? 32'h200 + i : 32'h100 + i);
    end
    idle(); cyc();

    // Load RAW
    do_reset();
    issue_load = 1; issue_rd = 7;
    #1 chk("raw_issue_ready", issue_ready, 1);
    cyc();
    issue_load = 0; rs1_id = 7;
    for (int i = 0; i < 3; i++) begin
      #1 chk("raw_stall_hold", stall_o, 1);
      cyc();
    end
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'hCAFE;
    #1;
    chk("raw_stall_on_grant", stall_o, 1);
    chk("raw_lsu_ready", lsu_ready, 1);
    cyc();
    lsu_valid = 0;
    #1;
    chk("raw_stall_drop", stall_o, 0);
    chk("raw_wen", rf_w_en, 1);
    chk("raw_rd", rf_rd_id, 7);
    chk("raw_wdata", rf_wdata, 32'hCAFE);
    cyc();

    // WAW hold
    idle();
    issue_load = 1; issue_rd = 9;
    cyc();
    issue_load = 0;
    alu_valid = 1; alu_rd = 9; alu_data = 32'h111;
    for (int i = 0; i < 3; i++) begin
      #1 chk("waw_alu_blocked", alu_ready, 0);
      cyc();
    end
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h222;
    #1;
    chk("waw_lsu_first", lsu_ready, 1);
    chk("waw_alu_wait", alu_ready, 0);
    cyc();
    lsu_valid = 0;
    #1;
    chk("waw_alu_after", alu_ready, 1);
    chk("waw_lsu_value", rf_wdata, 32'h222);
    cyc();
    alu_valid = 0;
    #1;
    chk("waw_alu_last_wen", rf_w_en, 1);
    chk("waw_alu_last", rf_wdata, 32'h111);
    cyc();

    // Limits
    do_reset();
    issue_load = 1;
    for (int i = 1; i <= 4; i++) begin
      issue_rd = 5'(i);
      #1 chk("lim_issue_ok", issue_ready, 1);
      cyc();
    end
    issue_rd = 5;
    #1 chk("lim_full", issue_ready, 0);
    cyc();
    issue_load = 0; lsu_valid = 1; lsu_rd = 1; lsu_data = 32'h1;
    cyc();
    issue_load = 1; issue_rd = 5; lsu_rd = 2; lsu_data = 32'h2;
    #1;
    chk("lim_same_issue", issue_ready, 1);
    chk("lim_same_lsu", lsu_ready, 1);
    cyc();
    lsu_valid = 0; issue_rd = 6;
    #1 chk("lim_count_kept", issue_ready, 1);
    cyc();
    issue_rd = 8;
    #1 chk("lim_full_again", issue_ready, 0);
    issue_load = 0; issue_rd = 3; rs1_id = 2; rs2_id = 5;
    #1;
    chk("lim_pending_dest", issue_ready, 0);
    chk("lim_stall_rs2", stall_o, 1);
    rs2_id = 0;
    #1 chk("lim_rs1_cleared", stall_o, 0);
    cyc();

    // Issue to x0 and ALU write to x0
    do_reset();
    issue_load = 1; issue_rd = 0;
    #1 chk("x0_issue_ready", issue_ready, 1);
    cyc();
    issue_load = 0;
    alu_valid = 1; alu_rd = 0; alu_data = 32'h5;
    #1 chk("x0_alu_ready", alu_ready, 1);
    cyc();
    alu_valid = 0;
    #1 chk("x0_no_wen", rf_w_en, 0);
    cyc();

    // Reset with loads in flight
    issue_load = 1; issue_rd = 10; cyc();
    issue_rd = 11; cyc();
    issue_load = 0; issue_rd = 10; rs1_id = 10; rs2_id = 11;
    #1 chk("mid_stall_before", stall_o, 1);
    rst = 1; cyc(); rst = 0;
    #1;
    chk("mid_stall", stall_o, 0);
    chk("mid_issue_ready", issue_ready, 1);
    chk("mid_wen", rf_w_en, 0);
    cyc();

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      alu_valid  = ($urandom_range(0, 99) < 50);
      alu_rd     = 5'($urandom_range(0, 7));
      alu_data   = $urandom;
      lsu_valid  = ($urandom_range(0, 99) < 35);
      lsu_rd     = 5'($urandom_range(0, 7));
      lsu_data   = $urandom;
      issue_load = ($urandom_range(0, 99) < 40);
      issue_rd   = 5'($urandom_range(0, 7));
      rs1_id     = 5'($urandom_range(0, 7));
      rs2_id     = 5'($urandom_range(0, 7));
      rst        = ($urandom_range(0, 99) < 2);
      cyc();
      rst = 0;
    end
    idle();
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
